// File: rtl/peripheral_axi4_read_master_pkg.sv
// Shared AXI4 constants, FSM state encoding and the request legality check
// used by the AXI4 read master.
//   - AXI_ADDR_WIDTH_DEF / AXI_DATA_WIDTH_DEF : default bus widths
//   - AXI_BURST_INCR, AXI_RESP_*              : AXI4 field encodings
//   - rm_state_e                              : read master FSM states
//   - req_is_bad()                            : misalignment / 4KB-crossing test
package peripheral_axi4_read_master_pkg;

  localparam int AXI_ADDR_WIDTH_DEF = 64;
  localparam int AXI_DATA_WIDTH_DEF = 64;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RM_IDLE = 2'd0,
    RM_ADDR = 2'd1,
    RM_DATA = 2'd2,
    RM_ERR  = 2'd3
  } rm_state_e;

  // A request is rejected when the start address is not aligned to the beat
  // size, or when the whole burst would run past the end of its 4KB page.
  // Only the page offset matters for both tests.
  function automatic logic req_is_bad(input logic [11:0] page_off,
                                      input logic [2:0]  size,
                                      input logic [7:0]  len);
    logic [7:0]  mask;
    logic [16:0] span;
    mask = (8'd1 << size) - 8'd1;
    span = 17'(page_off) + ((17'(len) + 17'd1) << size);
    return (|(page_off[7:0] & mask)) || (span > 17'd4096);
  endfunction

endpackage

// File: rtl/peripheral_axi4_read_master_if.sv
// AXI4 read-channel bundle (AR + R) between the read master and a slave.
//   master modport : drives AR fields/arvalid and rready, samples the rest
//   slave modport  : the mirror image, used by a slave model or interconnect
interface peripheral_axi4_read_master_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]   axi_arid_o;
  logic [ADDR_W-1:0] axi_araddr_o;
  logic [7:0]        axi_arlen_o;
  logic [2:0]        axi_arsize_o;
  logic [1:0]        axi_arburst_o;
  logic [2:0]        axi_arprot_o;
  logic              axi_arvalid_o;
  logic              axi_arready_i;
  logic [ID_W-1:0]   axi_rid_i;
  logic [DATA_W-1:0] axi_rdata_i;
  logic [1:0]        axi_rresp_i;
  logic              axi_rlast_i;
  logic              axi_rvalid_i;
  logic              axi_rready_o;

  modport master (
    output axi_arid_o, axi_araddr_o, axi_arlen_o, axi_arsize_o,
           axi_arburst_o, axi_arprot_o, axi_arvalid_o, axi_rready_o,
    input  axi_arready_i, axi_rid_i, axi_rdata_i, axi_rresp_i,
           axi_rlast_i, axi_rvalid_i
  );

  modport slave (
    input  axi_arid_o, axi_araddr_o, axi_arlen_o, axi_arsize_o,
           axi_arburst_o, axi_arprot_o, axi_arvalid_o, axi_rready_o,
    output axi_arready_i, axi_rid_i, axi_rdata_i, axi_rresp_i,
           axi_rlast_i, axi_rvalid_i
  );
endinterface

// File: rtl/peripheral_axi4_read_master_rbuf.sv
// Small synchronous FIFO for returned read beats.
//   clk, rst_n : clock, asynchronous active-low reset (flushes the FIFO)
//   push, din  : write an entry (ignored while full)
//   pop        : drop the head entry (ignored while empty)
//   dout       : head entry, forced to zero while empty
//   full, empty, count : occupancy status
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module peripheral_axi4_read_master_rbuf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Stale storage is never exposed: an empty FIFO presents all zeros.
  assign dout    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      // Simultaneous push and pop leaves the count unchanged.
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end
endmodule

// File: rtl/peripheral_axi4_read_master.sv
// AXI4 read master: turns one core read request into one INCR burst and
// returns the beats through a small FIFO. One transaction outstanding.
//   aclk, aresetn            : clock, asynchronous active-low reset
//   req_i/adr_i/size_i/len_i : core request (level), start address, beat size, beats-1
//   ack_o                    : request accepted (one-cycle pulse, combinational in IDLE)
//   q_o/qlast_o/qerr_o       : returned beat, end-of-request flag, error flag
//   qvalid_o/qready_i        : returned beat handshake
//   axi                      : AR/R channels (master side)
// Bad requests (misaligned or 4KB crossing) issue no AR and return one error beat.
module peripheral_axi4_read_master
  import peripheral_axi4_read_master_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = AXI_ADDR_WIDTH_DEF,
  parameter int AXI_DATA_WIDTH = AXI_DATA_WIDTH_DEF,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int TRANSACTION_ID = 0,
  parameter int BUFFER_DEPTH   = 2
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      req_i,
  input  logic [AXI_ADDR_WIDTH-1:0] adr_i,
  input  logic [2:0]                size_i,
  input  logic [7:0]                len_i,
  output logic                      ack_o,
  output logic [AXI_DATA_WIDTH-1:0] q_o,
  output logic                      qvalid_o,
  output logic                      qlast_o,
  output logic                      qerr_o,
  input  logic                      qready_i,
  peripheral_axi4_read_master_if.master axi
);
  localparam logic [1:0] S_IDLE = RM_IDLE;
  localparam logic [1:0] S_ADDR = RM_ADDR;
  localparam logic [1:0] S_DATA = RM_DATA;
  localparam logic [1:0] S_ERR  = RM_ERR;
  localparam logic [AXI_ID_WIDTH-1:0] TID = AXI_ID_WIDTH'(TRANSACTION_ID);
  localparam int EW = AXI_DATA_WIDTH + 2;

  logic [1:0]                state_reg, state_next;
  logic [AXI_ADDR_WIDTH-1:0] addr_reg;
  logic [2:0]                size_reg;
  logic [7:0]                len_reg;
  logic [7:0]                beat_reg;

  logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(BUFFER_DEPTH):0] fifo_count;
  logic [EW-1:0]             push_entry, head_entry;
  logic                      own_beat, beat_is_len, end_beat, resp_err, req_bad;

  assign req_bad = req_is_bad(adr_i[11:0], size_i, len_i);
  // Gated by reset so nothing is acknowledged while the block is held in reset.
  assign ack_o   = aresetn & req_i & (state_reg == S_IDLE);

  assign axi.axi_arid_o    = TID;
  assign axi.axi_araddr_o  = addr_reg;
  assign axi.axi_arlen_o   = len_reg;
  assign axi.axi_arsize_o  = size_reg;
  assign axi.axi_arburst_o = AXI_BURST_INCR;
  assign axi.axi_arprot_o  = 3'b000;
  assign axi.axi_arvalid_o = (state_reg == S_ADDR);
  assign axi.axi_rready_o  = (state_reg == S_DATA) && (int'(fifo_count) < BUFFER_DEPTH);

  // Foreign-id beats still complete their handshake but are never stored.
  assign own_beat    = axi.axi_rvalid_i & axi.axi_rready_o & (axi.axi_rid_i == TID);
  assign beat_is_len = (beat_reg == len_reg);
  // The request ends on rlast, or at beat len if the slave omits rlast.
  assign end_beat    = axi.axi_rlast_i | beat_is_len;
  assign resp_err    = (axi.axi_rresp_i == AXI_RESP_SLVERR) ||
                       (axi.axi_rresp_i == AXI_RESP_DECERR);

  always_comb begin
    state_next = state_reg;
    fifo_push  = 1'b0;
    push_entry = '0;
    case (state_reg)
      S_IDLE: if (req_i) state_next = req_bad ? S_ERR : S_ADDR;
      S_ADDR: if (axi.axi_arready_i) state_next = S_DATA;
      S_DATA: begin
        if (own_beat) begin
          fifo_push = 1'b1;
          // rlast disagreeing with the beat count is reported on that beat.
          push_entry = {axi.axi_rdata_i, end_beat,
                        resp_err | (axi.axi_rlast_i ^ beat_is_len)};
          if (end_beat) state_next = S_IDLE;
        end
      end
      S_ERR: begin
        if (!fifo_full) begin
          fifo_push  = 1'b1;
          push_entry = {{AXI_DATA_WIDTH{1'b0}}, 2'b11};
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      size_reg  <= '0;
      len_reg   <= '0;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && req_i) begin
        addr_reg <= adr_i;
        size_reg <= size_i;
        len_reg  <= len_i;
        beat_reg <= '0;
      end else if (own_beat) begin
        beat_reg <= beat_reg + 8'd1;
      end
    end
  end

  assign fifo_pop = qvalid_o & qready_i;
  assign qvalid_o = ~fifo_empty;
  assign {q_o, qlast_o, qerr_o} = head_entry;

  peripheral_axi4_read_master_rbuf #(
    .WIDTH (EW),
    .DEPTH (BUFFER_DEPTH)
  ) u_rbuf (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (fifo_push),
    .din   (push_entry),
    .pop   (fifo_pop),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_peripheral_axi4_read_master.sv
// Self-checking bench for peripheral_axi4_read_master: directed steps plus a
// randomized loop, with an AXI slave model, a core-side consumer and a monitor.
module tb_peripheral_axi4_read_master;
  import peripheral_axi4_read_master_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [3:0] TID = 4'd0;

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic        e;
  } beat_t;

  logic        aclk;
  logic        aresetn;
  logic        req;
  logic [63:0] adr;
  logic [2:0]  size;
  logic [7:0]  len;
  logic        ack;
  logic [63:0] q;
  logic        qvalid, qlast, qerr, qready;

  peripheral_axi4_read_master_if #(.ADDR_W(64), .DATA_W(64), .ID_W(4)) bus ();

  peripheral_axi4_read_master #(
    .AXI_ADDR_WIDTH (64),
    .AXI_DATA_WIDTH (64),
    .AXI_ID_WIDTH   (4),
    .TRANSACTION_ID (0),
    .BUFFER_DEPTH   (DEPTH)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .req_i    (req),
    .adr_i    (adr),
    .size_i   (size),
    .len_i    (len),
    .ack_o    (ack),
    .q_o      (q),
    .qvalid_o (qvalid),
    .qlast_o  (qlast),
    .qerr_o   (qerr),
    .qready_i (qready),
    .axi      (bus)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int checks = 0;
  int failures = 0;

  // Slave configuration and observations
  logic [63:0] data_tab [256];
  logic [1:0]  resp_tab [256];
  int          ar_delay = 0;
  int          slv_last_pos = -1;   // -1: rlast on beat arlen; beyond arlen: never
  int          slv_foreign_at = -1; // insert a foreign-id beat before this own beat
  int          ar_count = 0;
  bit          ar_unstable = 0;
  logic [63:0] cap_addr;
  logic [7:0]  cap_len;
  logic [2:0]  cap_size;

  // Consumer / monitor state
  int    qready_mode = 0;
  beat_t got_q[$];
  beat_t exp_q[$];
  int    acc_cnt = 0, pop_cnt = 0, full_viol = 0, arvalid_cycles = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rule: misaligned start or a burst running past its 4KB page.
  function automatic bit model_bad(input longint unsigned a, input int s, input int l);
    longint unsigned bytes;
    bytes = longint'(1) << s;
    return ((a % bytes) != 0) || (((a % 4096) + longint'(l + 1) * bytes) > 4096);
  endfunction

  task automatic send_beat(input logic [3:0] id, input logic [63:0] d, input logic [1:0] resp,
                           input logic last, output bit abort);
    bit hs;
    abort = 1'b0;
    bus.axi_rid_i    = id;
    bus.axi_rdata_i  = d;
    bus.axi_rresp_i  = resp;
    bus.axi_rlast_i  = last;
    bus.axi_rvalid_i = 1'b1;
    forever begin
      #1 hs = bus.axi_rready_o;
      @(negedge aclk);
      if (!aresetn) begin abort = 1'b1; break; end
      if (hs) break;
    end
  endtask

  // AXI slave model: all driving happens on the falling edge.
  initial begin : slave
    bit abort;
    int lp, n;
    bus.axi_arready_i = 1'b0;
    bus.axi_rvalid_i  = 1'b0;
    bus.axi_rid_i     = '0;
    bus.axi_rdata_i   = '0;
    bus.axi_rresp_i   = '0;
    bus.axi_rlast_i   = 1'b0;
    forever begin
      @(negedge aclk);
      if (aresetn && bus.axi_arvalid_o) begin
        cap_addr = bus.axi_araddr_o;
        cap_len  = bus.axi_arlen_o;
        cap_size = bus.axi_arsize_o;
        ar_count++;
        for (int d = 0; d < ar_delay; d++) begin
          @(negedge aclk);
          if (!bus.axi_arvalid_o || bus.axi_araddr_o !== cap_addr ||
              bus.axi_arlen_o !== cap_len || bus.axi_arsize_o !== cap_size)
            ar_unstable = 1'b1;
        end
        bus.axi_arready_i = 1'b1;
        @(negedge aclk);
        bus.axi_arready_i = 1'b0;
        lp = (slv_last_pos < 0) ? int'(cap_len) : slv_last_pos;
        n  = (lp < int'(cap_len)) ? lp + 1 : int'(cap_len) + 1;
        abort = 1'b0;
        for (int i = 0; i < n && !abort; i++) begin
          if (i == slv_foreign_at)
            send_beat(TID + 4'd1, {$urandom, $urandom}, AXI_RESP_OKAY, 1'b0, abort);
          if (!abort)
            send_beat(TID, data_tab[i], resp_tab[i], (i == lp), abort);
        end
        bus.axi_rvalid_i = 1'b0;
        bus.axi_rlast_i  = 1'b0;
      end
    end
  end

  // Core-side consumer
  initial begin : consumer
    bit tog;
    beat_t b;
    tog = 1'b0;
    qready = 1'b0;
    forever begin
      @(negedge aclk);
      case (qready_mode)
        0:       qready = 1'b1;
        1:       begin tog = !tog; qready = tog; end
        default: qready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (qvalid && qready) begin
        b.d = q; b.l = qlast; b.e = qerr;
        got_q.push_back(b);
      end
    end
  end

  // Occupancy monitor: beats accepted minus beats popped is the FIFO fill.
  initial begin : monitor
    forever begin
      @(negedge aclk);
      #2;
      if (!aresetn) begin
        acc_cnt = 0;
        pop_cnt = 0;
      end else begin
        if ((acc_cnt - pop_cnt) >= DEPTH && bus.axi_rready_o) full_viol++;
        if (bus.axi_rvalid_i && bus.axi_rready_o && bus.axi_rid_i == TID) acc_cnt++;
        if (qvalid && qready) pop_cnt++;
        if (bus.axi_arvalid_o) arvalid_cycles++;
      end
    end
  end

  task automatic do_req(input logic [63:0] a, input logic [2:0] s, input logic [7:0] l,
                        input string tag);
    beat_t e;
    bit    bad, rl, il;
    int    lp, n, ar0, waited;
    bad = model_bad(a, int'(s), int'(l));
    exp_q.delete();
    if (bad) begin
      e.d = '0; e.l = 1'b1; e.e = 1'b1;
      exp_q.push_back(e);
    end else begin
      lp = (slv_last_pos < 0) ? int'(l) : slv_last_pos;
      n  = (lp < int'(l)) ? lp + 1 : int'(l) + 1;
      for (int i = 0; i < n; i++) begin
        rl = (i == lp);
        il = (i == int'(l));
        e.d = data_tab[i];
        e.l = rl | il;
        e.e = resp_tab[i][1] | (rl != il);
        exp_q.push_back(e);
      end
    end
    got_q.delete();
    acc_cnt = 0; pop_cnt = 0; full_viol = 0; arvalid_cycles = 0; ar_unstable = 1'b0;
    ar0 = ar_count;
    @(negedge aclk);
    req = 1'b1; adr = a; size = s; len = l;
    #1 check({tag, "_ack"}, ack, 1);
    @(negedge aclk);
    req = 1'b0;
    waited = 0;
    while (got_q.size() < exp_q.size() && waited < 3000) begin
      @(negedge aclk);
      waited++;
    end
    repeat (6) @(negedge aclk);
    check({tag, "_nbeats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), {got_q[i].d, got_q[i].l, got_q[i].e},
            {exp_q[i].d, exp_q[i].l, exp_q[i].e});
    check({tag, "_ar_issued"}, ar_count - ar0, bad ? 0 : 1);
    if (!bad) begin
      check({tag, "_araddr"}, cap_addr, a);
      check({tag, "_arlen_size"}, {cap_len, cap_size}, {l, s});
      check({tag, "_ar_stable"}, ar_unstable, 0);
      check({tag, "_rready_full"}, full_viol, 0);
    end
    $display("TXN %s addr=%0h size=%0d len=%0d beats=%0d", tag, a, s, l, got_q.size());
  endtask

  task automatic fill_tab(input int n);
    for (int i = 0; i < n; i++) begin
      data_tab[i] = {$urandom, $urandom};
      resp_tab[i] = AXI_RESP_OKAY;
    end
  endtask

  initial begin : main
    logic [63:0] a;
    logic [2:0]  s;
    logic [7:0]  l;
    int waited;
    aresetn = 1'b1;
    req = 1'b0; adr = '0; size = '0; len = '0;
    #2 aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    check("rst_ctrl", {bus.axi_arvalid_o, bus.axi_rready_o, qvalid, ack, qlast, qerr}, 0);
    check("rst_q", q, 0);
    check("rst_arburst", bus.axi_arburst_o, 2'b01);
    check("rst_arid", bus.axi_arid_o, TID);
    check("rst_araddr", {bus.axi_araddr_o, bus.axi_arlen_o, bus.axi_arsize_o}, 0);
    @(negedge aclk);
    aresetn = 1'b1;

    // 1. single beat
    fill_tab(1);
    data_tab[0] = 64'hDEADBEEF_CAFEF00D;
    do_req(64'h1000, 3'd3, 8'd0, "t1_single");
    check("t1_arvalid_cycles", arvalid_cycles, 1);

    // 2. burst with consumer backpressure
    fill_tab(4);
    qready_mode = 1;
    do_req(64'h2000, 3'd3, 8'd3, "t2_backpressure");
    qready_mode = 0;

    // 3. slave error on beat 2 of 4
    fill_tab(4);
    resp_tab[1] = AXI_RESP_SLVERR;
    do_req(64'h2100, 3'd3, 8'd3, "t3_slverr");

    // 4. rejected requests
    do_req(64'h1004, 3'd3, 8'd0, "t4_misaligned");
    do_req(64'h0FF8, 3'd3, 8'd1, "t4_cross4k");
    fill_tab(1);
    do_req(64'h0FF8, 3'd3, 8'd0, "t4_page_end_ok");

    // 5. slow AR and a foreign-id beat
    fill_tab(3);
    ar_delay = 5;
    slv_foreign_at = 1;
    do_req(64'h3000, 3'd2, 8'd2, "t5_slow_ar");
    check("t5_arvalid_cycles", arvalid_cycles, 6);
    ar_delay = 0;
    slv_foreign_at = -1;

    // rlast missing, then rlast early
    fill_tab(3);
    slv_last_pos = 999;
    do_req(64'h3800, 3'd3, 8'd2, "t5_rlast_missing");
    fill_tab(4);
    slv_last_pos = 1;
    do_req(64'h3900, 3'd3, 8'd3, "t5_rlast_early");
    slv_last_pos = -1;

    // 6. reset in the middle of a burst
    fill_tab(4);
    got_q.delete();
    @(negedge aclk);
    req = 1'b1; adr = 64'h4000; size = 3'd3; len = 8'd3;
    #1 check("t6_ack", ack, 1);
    @(negedge aclk);
    req = 1'b0;
    waited = 0;
    while (got_q.size() < 1 && waited < 200) begin
      @(negedge aclk);
      #3;
      waited++;
    end
    check("t6_first_beat", got_q.size(), 1);
    aresetn = 1'b0;
    #1;
    check("t6_rst_ctrl", {bus.axi_arvalid_o, bus.axi_rready_o, qvalid, ack, qlast, qerr}, 0);
    check("t6_rst_q", q, 0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (10) @(negedge aclk);
    check("t6_no_stale_beats", got_q.size(), 1);
    check("t6_qvalid_idle", qvalid, 0);
    $display("TXN t6_reset_mid_burst beats_before_reset=%0d", got_q.size());
    fill_tab(4);
    do_req(64'h4000, 3'd3, 8'd3, "t6_after_reset");

    // Randomized requests
    for (int k = 0; k < 16; k++) begin
      s = 3'($urandom_range(0, 3));
      l = 8'($urandom_range(0, 7));
      a = (64'($urandom_range(1, 15)) << 12) | 64'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << s) - 64'd1);
      fill_tab(int'(l) + 1);
      for (int i = 0; i <= int'(l); i++)
        if ($urandom_range(0, 5) == 0) resp_tab[i] = 2'($urandom_range(0, 3));
      ar_delay       = $urandom_range(0, 3);
      qready_mode    = $urandom_range(0, 2);
      slv_foreign_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, int'(l)) : -1;
      do_req(a, s, l, $sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
